elevator_call_scheduler: RTL and testbench
==========================================

Name: elevator_call_scheduler

Overview:
- Latches floor calls from car and hall buttons into a pending-call register.
- Picks the next target floor using a LOOK policy: keep the current travel direction while calls remain ahead, otherwise reverse.
- Issues each target to the motion controller over a valid/ready handshake, and clears the call when the car reports arrival.
- Sits between the button inputs and elevator_controller, which owns up/down motion and door sequencing.

Parameters:
- N_FLOORS, 8, number of served floors (2..16).
- FLOOR_W, 3, floor index width; must equal clog2(N_FLOORS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- call_req  in  N_FLOORS  call bitmask; each bit sampled every clk edge and sets the matching pending bit.
- cur_floor  in  FLOOR_W  current car floor from the motion controller.
- arrived  in  1  one-cycle pulse: car stopped at cur_floor and the door cycle is done.
- tgt_ready  in  1  motion controller accepts tgt_floor.
- tgt_valid  out  1  tgt_floor is valid; held until accepted.
- tgt_floor  out  FLOOR_W  target floor.
- dir_up  out  1  scheduled direction is up.
- dir_down  out  1  scheduled direction is down; never high together with dir_up.
- pending  out  N_FLOORS  registered outstanding calls.
- idle  out  1  FSM in IDLE and pending==0.

Behaviour:
- Reset (rst=0, any time, including mid-handshake):
  - pending=0, tgt_valid=0, tgt_floor=0, dir_up=0, dir_down=0, idle=1, state=IDLE.
  - An in-flight target is dropped.
- Pending register update each edge: pending <= (pending | call_req) & ~clr.
  - clr is the one-hot mask of cur_floor when arrived is high in WAIT_ARRIVE; otherwise 0.
  - A set and a clear on the same bit in the same cycle: clear wins. The arrival serves that call.
  - cur_floor >= N_FLOORS gives clr=0.
- FSM states: IDLE, SELECT, ISSUE, WAIT_ARRIVE.
- IDLE:
  - idle=1 and direction outputs 0.
  - pending!=0 → SELECT.
- SELECT (exactly 1 cycle): evaluate in order, first match wins.
  - Current direction up and any pending above cur_floor: target = lowest pending above, dir_up=1.
  - Current direction down and any pending below cur_floor: target = highest pending below, dir_down=1.
  - Any pending above: lowest above, dir_up=1.
  - Any pending below: highest below, dir_down=1.
  - Otherwise (only cur_floor pending): target = cur_floor, both direction outputs 0.
  - Register tgt_floor, then → ISSUE.
- ISSUE:
  - tgt_valid=1.
  - tgt_floor and the direction outputs are stable until the cycle where tgt_valid & tgt_ready.
  - On that cycle → WAIT_ARRIVE and tgt_valid drops the next cycle.
  - New calls only update pending; they never alter the target.
- WAIT_ARRIVE:
  - On arrived: clear the bit as above. If the post-clear pending is nonzero → SELECT, else → IDLE with direction outputs cleared.
  - arrived in any other state is ignored.
- Latency: a call sampled at edge E0 while idle → SELECT after E1 → tgt_valid=1 after E2.
- Direction persists across SELECT iterations and is cleared only on entering IDLE.

Optional Feature:
- Macro: ELEVATOR_PREEMPT_EN.
- Defined:
  - In WAIT_ARRIVE, a pending call strictly between cur_floor and tgt_floor in the travel direction triggers a return to SELECT.
  - The new, nearer target is re-issued via ISSUE. The original target stays pending.
  - Preempt is evaluated one cycle after the call registers. It does not fire in the cycle arrived is high.
- Undefined: WAIT_ARRIVE leaves only on arrived.

Decomposition:
- Package elevator_pkg:
  - state encoding (IDLE, SELECT, ISSUE, WAIT_ARRIVE);
  - direction encoding (NONE/UP/DOWN);
  - default N_FLOORS and FLOOR_W constants.
- Sub-module elevator_floor_picker:
  - combinational;
  - inputs pending and cur_floor;
  - outputs any_above, lowest_above, any_below, highest_below, at_cur.
- The scheduler instantiates it once.

Test Plan:
- Reset: assert rst=0 while in ISSUE with tgt_floor=5 → next sample shows tgt_valid=0, pending=0, idle=1, dir_up=dir_down=0.
- Single call: cur_floor=0, call_req=8'h10 for 1 cycle → tgt_valid=1 at second edge after sampling, tgt_floor=4, dir_up=1. Then tgt_ready=1, cur_floor=4, arrived pulse → pending=0, idle=1.
- LOOK order: cur_floor=3, direction up, pending floors {1,5,7} → issued targets 5, then 7, then 1. dir_down=1 only for target 1.
- Backpressure: tgt_ready=0 for 10 cycles with call_req=8'h02 injected → tgt_floor and dir outputs unchanged, tgt_valid held, pending[1]=1.
- Collision: arrived at cur_floor=5 with call_req bit5=1 in the same cycle → pending[5]=0 afterwards.
- Preempt: travelling 0→6, call at floor 3. With ELEVATOR_PREEMPT_EN → tgt_valid re-asserted with tgt_floor=3, pending[6] still 1. Without the macro → no new tgt_valid until arrived.

Source files
------------

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared state/direction encodings and default sizing for the call scheduler
package elevator_pkg;

    localparam int N_FLOORS_DEF = 8;
    localparam int FLOOR_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_WAIT_ARRIVE
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_e;

endpackage

// File: rtl/elevator_floor_picker.sv
// rtl/elevator_floor_picker.sv - combinational nearest-pending-floor search above and below the car
module elevator_floor_picker
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = FLOOR_W_DEF
) (
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  cur_floor,
    output logic                any_above,
    output logic [FLOOR_W-1:0]  lowest_above,
    output logic                any_below,
    output logic [FLOOR_W-1:0]  highest_below,
    output logic                at_cur
);

    always_comb begin
        any_above     = 1'b0;
        lowest_above  = '0;
        any_below     = 1'b0;
        highest_below = '0;
        at_cur        = 1'b0;
        // Scan downward so the last hit above the car is the lowest one.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                any_above    = 1'b1;
                lowest_above = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                any_below     = 1'b1;
                highest_below = FLOOR_W'(i);
            end
        end
        if (int'(cur_floor) < N_FLOORS) begin
            at_cur = pending[cur_floor];
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// rtl/elevator_call_scheduler.sv - LOOK call scheduler; ELEVATOR_PREEMPT_EN enables nearer-call retargeting
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = N_FLOORS_DEF,
    parameter int FLOOR_W  = FLOOR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                arrived,
    input  logic                tgt_ready,
    output logic                tgt_valid,
    output logic [FLOOR_W-1:0]  tgt_floor,
    output logic                dir_up,
    output logic                dir_down,
    output logic [N_FLOORS-1:0] pending,
    output logic                idle
);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    tgt_q, tgt_d;
    logic [N_FLOORS-1:0]   pending_q, pending_d, clr;

    logic                  any_above, any_below, at_cur;
    logic [FLOOR_W-1:0]    lowest_above, highest_below;

    elevator_floor_picker #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_picker (
        .pending       (pending_q),
        .cur_floor     (cur_floor),
        .any_above     (any_above),
        .lowest_above  (lowest_above),
        .any_below     (any_below),
        .highest_below (highest_below),
        .at_cur        (at_cur)
    );

    // Clear beats a same-cycle set: the arrival itself serves that call.
    always_comb begin
        clr = '0;
        if ((state_q == ST_WAIT_ARRIVE) && arrived && (int'(cur_floor) < N_FLOORS)) begin
            clr = N_FLOORS'(1) << cur_floor;
        end
        pending_d = (pending_q | call_req) & ~clr;
    end

`ifdef ELEVATOR_PREEMPT_EN
    logic preempt;

    always_comb begin
        preempt = ((dir_q == DIR_UP)   && any_above && (lowest_above  < tgt_q)) ||
                  ((dir_q == DIR_DOWN) && any_below && (highest_below > tgt_q));
    end
`endif

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_SELECT;
                end
            end
            ST_SELECT: begin
                state_d = ST_ISSUE;
                if ((dir_q == DIR_UP) && any_above) begin
                    tgt_d = lowest_above;
                    dir_d = DIR_UP;
                end else if ((dir_q == DIR_DOWN) && any_below) begin
                    tgt_d = highest_below;
                    dir_d = DIR_DOWN;
                end else if (any_above) begin
                    tgt_d = lowest_above;
                    dir_d = DIR_UP;
                end else if (any_below) begin
                    tgt_d = highest_below;
                    dir_d = DIR_DOWN;
                end else if (at_cur) begin
                    tgt_d = cur_floor;
                    dir_d = DIR_NONE;
                end else begin
                    state_d = ST_IDLE;
                    dir_d   = DIR_NONE;
                end
            end
            ST_ISSUE: begin
                if (tgt_ready) begin
                    state_d = ST_WAIT_ARRIVE;
                end
            end
            ST_WAIT_ARRIVE: begin
                if (arrived) begin
                    if (pending_d != '0) begin
                        state_d = ST_SELECT;
                    end else begin
                        state_d = ST_IDLE;
                        dir_d   = DIR_NONE;
                    end
                end
`ifdef ELEVATOR_PREEMPT_EN
                else if (preempt) begin
                    state_d = ST_SELECT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                dir_d   = DIR_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_NONE;
            tgt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            tgt_q     <= tgt_d;
            pending_q <= pending_d;
        end
    end

    assign tgt_valid = (state_q == ST_ISSUE);
    assign tgt_floor = tgt_q;
    assign dir_up    = (dir_q == DIR_UP);
    assign dir_down  = (dir_q == DIR_DOWN);
    assign pending   = pending_q;
    assign idle      = (state_q == ST_IDLE) && (pending_q == '0);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb/tb_elevator_call_scheduler.sv - directed and randomized checks of the call scheduler against a LOOK model
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] call_req;
    logic [2:0] cur_floor;
    logic       arrived;
    logic       tgt_ready;
    logic       tgt_valid;
    logic [2:0] tgt_floor;
    logic       dir_up;
    logic       dir_down;
    logic [7:0] pending;
    logic       idle;

    int checks   = 0;
    int failures = 0;

    // Reference state: outstanding calls, travel direction (0 none, 1 up, 2 down), car position.
    logic [7:0] m_pend = 8'h00;
    int         m_dir  = 0;
    int         m_car  = 0;
    int         m_tgt  = 0;

    always #5 clk = ~clk;

    elevator_call_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .call_req  (call_req),
        .cur_floor (cur_floor),
        .arrived   (arrived),
        .tgt_ready (tgt_ready),
        .tgt_valid (tgt_valid),
        .tgt_floor (tgt_floor),
        .dir_up    (dir_up),
        .dir_down  (dir_down),
        .pending   (pending),
        .idle      (idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] nxt;
        nxt = m_pend | call_req;
        if (arrived) nxt = nxt & ~(8'h01 << cur_floor);
        @(posedge clk);
        #1;
        m_pend = nxt;
    endtask

    // LOOK choice by distance: nearest call ahead in the current direction, else nearest in the other.
    function automatic void look(input logic [7:0] p, input int car, input int dir,
                                 output int tgt, output int nd);
        int up_t;
        int dn_t;
        up_t = -1;
        dn_t = -1;
        for (int d = 7; d >= 1; d--) begin
            if (car + d <= 7 && p[car + d]) up_t = car + d;
            if (car - d >= 0 && p[car - d]) dn_t = car - d;
        end
        if (dir == 1 && up_t >= 0)      begin tgt = up_t; nd = 1; end
        else if (dir == 2 && dn_t >= 0) begin tgt = dn_t; nd = 2; end
        else if (up_t >= 0)             begin tgt = up_t; nd = 1; end
        else if (dn_t >= 0)             begin tgt = dn_t; nd = 2; end
        else                            begin tgt = car;  nd = 0; end
    endfunction

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (tgt_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, tgt_valid, 1);
    endtask

    task automatic expect_tgt(input string tag, input int f, input bit up, input bit dn);
        wait_valid(tag);
        chk({tag, "_floor"}, tgt_floor, f);
        chk({tag, "_up"}, dir_up, up);
        chk({tag, "_down"}, dir_down, dn);
    endtask

    task automatic expect_model(input string tag);
        int t;
        int nd;
        look(m_pend, m_car, m_dir, t, nd);
        expect_tgt(tag, t, nd == 1, nd == 2);
        chk({tag, "_pending"}, pending, m_pend);
        m_dir = nd;
        m_tgt = t;
    endtask

    task automatic handshake();
        tgt_ready = 1'b1;
        tick();
        tgt_ready = 1'b0;
        chk("hs_drop", tgt_valid, 0);
    endtask

    task automatic arrive(input int f, input logic [7:0] calls);
        cur_floor = 3'(f);
        m_car     = f;
        tick();
        arrived  = 1'b1;
        call_req = calls;
        tick();
        arrived  = 1'b0;
        call_req = 8'h00;
        if (m_pend == 8'h00) m_dir = 0;
    endtask

    task automatic one_call(input logic [7:0] c);
        call_req = c;
        tick();
        call_req = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        call_req  = 8'h00;
        cur_floor = 3'd0;
        arrived   = 1'b0;
        tgt_ready = 1'b0;
        tick();
        tick();
        chk("rst_idle", idle, 1);
        chk("rst_valid", tgt_valid, 0);
        chk("rst_floor", tgt_floor, 0);
        chk("rst_dirs", {dir_up, dir_down}, 0);
        chk("rst_pending", pending, 0);
        rst = 1'b1;
        tick();

        // Reset in the middle of an offered target.
        one_call(8'h20);
        expect_tgt("rst_pre", 5, 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_valid", tgt_valid, 0);
        chk("rstmid_pending", pending, 0);
        chk("rstmid_idle", idle, 1);
        chk("rstmid_dirs", {dir_up, dir_down}, 0);
        chk("rstmid_floor", tgt_floor, 0);
        m_pend = 8'h00;
        m_dir  = 0;
        tick();
        rst = 1'b1;
        tick();

        // Single call with latency check.
        cur_floor = 3'd0;
        one_call(8'h10);
        chk("lat_pending", pending, 8'h10);
        chk("lat_e0", tgt_valid, 0);
        tick();
        chk("lat_e1", tgt_valid, 0);
        tick();
        chk("lat_e2", tgt_valid, 1);
        chk("single_floor", tgt_floor, 4);
        chk("single_up", dir_up, 1);
        handshake();
        arrive(4, 8'h00);
        chk("single_pending", pending, 0);
        chk("single_idle", idle, 1);
        chk("single_dir", {dir_up, dir_down}, 0);

        // Drive to floor 0, then up to 3 so the car sits at 3 travelling up.
        one_call(8'h01);
        expect_tgt("down0", 0, 0, 1);
        handshake();
        arrive(0, 8'h00);
        one_call(8'h08);
        expect_tgt("up3", 3, 1, 0);
        one_call(8'hA2);
        handshake();
        arrive(3, 8'h00);
        chk("look_pending", pending, 8'hA2);
        expect_tgt("look5", 5, 1, 0);
        for (int i = 0; i < 10; i++) begin
            call_req = 8'h02;
            tick();
            chk("bp_floor", tgt_floor, 5);
            chk("bp_valid", tgt_valid, 1);
            chk("bp_dirs", {dir_up, dir_down}, 2'b10);
        end
        call_req = 8'h00;
        chk("bp_pend1", pending[1], 1);
        handshake();
        arrive(5, 8'h20);
        chk("collide_pend5", pending[5], 0);
        chk("collide_pending", pending, 8'h82);
        expect_tgt("look7", 7, 1, 0);
        handshake();
        arrive(7, 8'h00);
        expect_tgt("look1", 1, 0, 1);
        handshake();
        arrive(1, 8'h00);
        chk("look_idle", idle, 1);

        // Travel 0 -> 6 with a call at 3 appearing en route.
        one_call(8'h01);
        expect_tgt("pre_down0", 0, 0, 1);
        handshake();
        arrive(0, 8'h00);
        one_call(8'h40);
        expect_tgt("pre_up6", 6, 1, 0);
        handshake();
        cur_floor = 3'd1;
        one_call(8'h08);
`ifdef ELEVATOR_PREEMPT_EN
        expect_tgt("preempt", 3, 1, 0);
        chk("preempt_pend6", pending[6], 1);
        handshake();
        arrive(3, 8'h00);
        expect_tgt("preempt_6", 6, 1, 0);
        handshake();
        arrive(6, 8'h00);
`else
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("nopreempt_valid", tgt_valid, 0);
        end
        arrive(6, 8'h00);
        expect_tgt("nopreempt_3", 3, 0, 1);
        handshake();
        arrive(3, 8'h00);
`endif
        chk("pre_idle", idle, 1);
        m_dir = 0;

        // Randomized traffic against the LOOK model.
        for (int it = 0; it < 40; it++) begin
            int         nbp;
            logic [7:0] c;
            if (m_pend == 8'h00) begin
                chk("rnd_idle", idle, 1);
                chk("rnd_idle_dirs", {dir_up, dir_down}, 0);
                m_dir = 0;
                one_call(8'(1 << $urandom_range(0, 7)) | 8'($urandom & $urandom));
            end
            expect_model("rnd");
            nbp = $urandom_range(0, 3);
            for (int k = 0; k < nbp; k++) begin
                call_req = 8'($urandom & $urandom & $urandom);
                tick();
                chk("rnd_hold", tgt_floor, m_tgt);
            end
            call_req = 8'h00;
            handshake();
            cur_floor = 3'(m_tgt);
            m_car     = m_tgt;
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
            c = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
            if ($urandom_range(0, 2) == 0) c = c | 8'(1 << m_tgt);
            arrive(m_tgt, c);
            chk("rnd_pending", pending, m_pend);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
